// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE control path: FSM state encoding and the context entry layout.
// Pure declarations; no timing or flow-control behaviour of its own.
package pe_ctrl_pkg;

  localparam int CTX_FUNC_W     = 3;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  last;
    logic [CTX_FUNC_W-1:0] func;
  } ctx_entry_t;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context register file: one synchronous write port, one asynchronous read port, cleared on reset.
// Write lands on the next rising edge; read is combinational; no backpressure.
module pe_ctx_mem
  import pe_ctrl_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ctx_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ctx_entry_t    rdata
);

  ctx_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_alu_sequencer.sv
// Steps the ALU through the programmed opcode list, one operand triple per entry.
// Step = handshake + ALU_LATENCY+1 wait + result hold; in_ready only in ISSUE, result held until out_ready.
module pe_alu_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH  = DATA_W_DEFAULT,
  parameter  int FUNC_WIDTH  = CTX_FUNC_W,
  parameter  int DEPTH       = 8,
  parameter  int ALU_LATENCY = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [FUNC_WIDTH:0]   cfg_wdata,
  output logic                  cfg_err,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic [DATA_WIDTH-1:0] in_data3,
  output logic [FUNC_WIDTH-1:0] alu_func,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [DATA_WIDTH-1:0] alu_in3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [AW-1:0]         out_pc
);

  state_e        state, state_nxt;
  logic [AW-1:0] pc;
  logic [3:0]    cnt;
  ctx_entry_t    cur;
  logic          kill, in_fire, out_fire, fin;

  pe_ctx_mem #(.DEPTH(DEPTH)) u_ctx (
    .clk   (clk),
    .resetn(resetn),
    .we    (cfg_we && (state == ST_IDLE)),
    .waddr (cfg_addr),
    .wdata (ctx_entry_t'(cfg_wdata)),
    .raddr (pc),
    .rdata (cur)
  );

  assign busy     = (state != ST_IDLE);
  assign kill     = abort && busy;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = (state == ST_HOLD) && out_ready && !kill;
  // An entry at the top of memory ends the run even without its last bit.
  assign fin      = cur.last || (pc == AW'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        in_ready = !abort;
        if (in_valid && !abort) state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (cnt == 4'd0) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = fin ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (kill) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc        <= '0;
      cnt       <= '0;
      cfg_err   <= 1'b0;
      done      <= 1'b0;
      alu_func  <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_in3   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= '0;
    end else begin
      cfg_err <= cfg_we && busy;
      done    <= out_fire && fin;
      if ((state == ST_IDLE) && start) pc <= '0;
      if (out_fire && !fin) pc <= pc + AW'(1);
      if (in_fire) begin
        alu_func <= cur.func;
        alu_in1  <= in_data1;
        alu_in2  <= in_data2;
        alu_in3  <= in_data3;
        cnt      <= 4'(ALU_LATENCY);
      end
      if ((state == ST_WAIT) && !kill) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          out_data  <= alu_result;
          out_pc    <= pc;
          out_valid <= 1'b1;
        end
      end
      if (out_fire || kill) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_alu_sequencer.sv
// Directed bench for pe_alu_sequencer with a registered one-cycle ALU model.
module tb_pe_alu_sequencer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_we, cfg_err, start, abort, busy, done;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_wdata;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data1, in_data2, in_data3;
  logic [2:0]  alu_func;
  logic [31:0] alu_in1, alu_in2, alu_in3, alu_result, out_data;
  logic [2:0]  out_pc;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int res_cnt = 0;

  always #5 clk = ~clk;

  pe_alu_sequencer #(.DATA_WIDTH(32), .FUNC_WIDTH(3), .DEPTH(8), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .alu_func(alu_func), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc)
  );

  // Reference ALU: result registered one cycle after its inputs.
  always @(posedge clk) begin
    case (alu_func)
      3'd0:    alu_result <= alu_in1 + alu_in2;
      3'd1:    alu_result <= alu_in1 - alu_in2;
      3'd2:    alu_result <= alu_in1 * alu_in2;
      3'd3:    alu_result <= alu_in1 & alu_in2;
      3'd4:    alu_result <= alu_in1 | alu_in2;
      3'd5:    alu_result <= alu_in1 - alu_in2 - alu_in3;
      3'd6:    alu_result <= alu_in1 ^ alu_in2;
      default: alu_result <= alu_in1 + alu_in2 + alu_in3;
    endcase
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (resetn && out_valid && out_ready) res_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  func;
    logic        last;
    logic [31:0] a, b, c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic lst, input logic [2:0] f);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = {lst, f};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_step(input logic [2:0] f, input logic lst, input logic [31:0] a, b, c,
                         input logic [31:0] exp, input logic [2:0] pc, input int hold);
    int k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data1 = a; in_data2 = b; in_data3 = c;
    @(negedge clk);
    in_valid = 1'b0;
    check("alu_func", {29'd0, alu_func}, {29'd0, f});
    check("alu_in1", alu_in1, a);
    check("alu_in2", alu_in2, b);
    check("alu_in3", alu_in3, c);
    k = 1;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    check("result_latency", k, LAT + 2);
    check("out_data", out_data, exp);
    check("out_pc", {29'd0, out_pc}, {29'd0, pc});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out_data", out_data, exp);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, {31'd0, lst});
    check("busy_after_step", {31'd0, busy}, {31'd0, !lst});
  endtask

  initial begin
    int d0, r0, ov;
    vecs[0] = '{3'd2, 1'b0, 32'd7,     32'd3,     32'd0,  32'd21};
    vecs[1] = '{3'd5, 1'b1, 32'd9,     32'd4,     32'd0,  32'd5};
    vecs[2] = '{3'd0, 1'b0, 32'd10,    32'd20,    32'd0,  32'd30};
    vecs[3] = '{3'd1, 1'b0, 32'd50,    32'd8,     32'd0,  32'd42};
    vecs[4] = '{3'd2, 1'b0, 32'd6,     32'd7,     32'd0,  32'd42};
    vecs[5] = '{3'd3, 1'b0, 32'hF0F0,  32'h0FF0,  32'd0,  32'h00F0};
    vecs[6] = '{3'd4, 1'b0, 32'hF000,  32'h000F,  32'd0,  32'hF00F};
    vecs[7] = '{3'd5, 1'b0, 32'd100,   32'd30,    32'd20, 32'd50};
    vecs[8] = '{3'd6, 1'b0, 32'hFF,    32'h0F,    32'd0,  32'hF0};
    vecs[9] = '{3'd7, 1'b0, 32'd1,     32'd2,     32'd3,  32'd6};

    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data1 = '0; in_data2 = '0; in_data3 = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_alu_func", {29'd0, alu_func}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_pc", {29'd0, out_pc}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Two-entry program from the table, out_ready tied high.
    for (int i = 0; i < 2; i++) cfg_write(3'(i), vecs[i].last, vecs[i].func);
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 2; i++)
      do_step(vecs[i].func, vecs[i].last, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, 3'(i), 0);
    repeat (3) @(negedge clk);
    check("two_step_done_count", done_cnt, d0 + 1);
    check("alu_func_holds", {29'd0, alu_func}, 32'd5);
    check("alu_in1_holds", alu_in1, 32'd9);

    // All eight entries with last=0: terminates at the top, no wrap.
    for (int i = 2; i < 10; i++) cfg_write(3'(i - 2), vecs[i].last, vecs[i].func);
    d0 = done_cnt; r0 = res_cnt;
    do_start();
    for (int i = 2; i < 10; i++)
      do_step(vecs[i].func, (i == 9), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, 3'(i - 2), 0);
    ov = 0;
    repeat (6) begin @(negedge clk); if (out_valid || busy) ov++; end
    check("no_wrap_activity", ov, 0);
    check("eight_results", res_cnt, r0 + 8);
    check("eight_done_count", done_cnt, d0 + 1);

    // Result held under backpressure for five cycles.
    cfg_write(3'd0, 1'b1, 3'd0);
    out_ready = 1'b0;
    do_start();
    do_step(3'd0, 1'b1, 32'd100, 32'd23, 32'd0, 32'd123, 3'd0, 5);

    // Context write during a run is dropped and flagged.
    cfg_write(3'd0, 1'b1, 3'd6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = {1'b1, 3'd1};
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
    @(negedge clk);
    check("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
    do_step(3'd6, 1'b1, 32'hAA, 32'h0F, 32'd0, 32'hA5, 3'd0, 0);
    do_start();
    do_step(3'd6, 1'b1, 32'hAA, 32'h0F, 32'd0, 32'hA5, 3'd0, 0);

    // Abort: in ISSUE it blocks the operand; in WAIT it kills the pending result.
    cfg_write(3'd0, 1'b0, 3'd0);
    cfg_write(3'd1, 1'b1, 3'd7);
    d0 = done_cnt; r0 = res_cnt;
    do_start();
    abort = 1'b1; in_valid = 1'b1; in_data1 = 32'd99;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_issue_busy", {31'd0, busy}, 32'd0);
    check("abort_issue_alu_in1", alu_in1, 32'hAA);
    do_start();
    in_valid = 1'b1; in_data1 = 32'd8; in_data2 = 32'd8; in_data3 = 32'd0;
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_wait_busy", {31'd0, busy}, 32'd0);
    ov = 0;
    repeat (5) begin @(negedge clk); if (out_valid) ov++; end
    check("abort_no_result", ov, 0);
    check("abort_no_done", done_cnt, d0);
    do_start();
    do_step(3'd0, 1'b0, 32'd4, 32'd5, 32'd0, 32'd9, 3'd0, 0);
    do_step(3'd7, 1'b1, 32'd1, 32'd1, 32'd1, 32'd3, 3'd1, 0);
    check("abort_rerun_results", res_cnt, r0 + 2);

    // Reset in HOLD with a pending result.
    cfg_write(3'd0, 1'b1, 3'd2);
    d0 = done_cnt;
    out_ready = 1'b0;
    do_start();
    in_valid = 1'b1; in_data1 = 32'd5; in_data2 = 32'd6; in_data3 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_reset_out_data", out_data, 32'd30);
    resetn = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_alu_func", {29'd0, alu_func}, 32'd0);
    check("mid_rst_alu_in", alu_in1 | alu_in2 | alu_in3, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", done_cnt, d0);
    check("mid_rst_no_cfg_err", {31'd0, cfg_err}, 32'd0);
    // Context was cleared, so entry 0 now issues opcode 0.
    do_start();
    in_valid = 1'b1; in_data1 = 32'd1; in_data2 = 32'd2; in_data3 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("ctx_cleared_func", {29'd0, alu_func}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_alu_sequencer.md
# pe_alu_sequencer

Sequences the PE tile's ALU through a short programmed list of `ALU_func` opcodes, one operand set per step. It holds a small context memory of opcodes and accepts operand triples over a valid/ready stream. It drives the ALU's `ALU_func` and `data_in1..3` from registers, waits a fixed ALU latency, and returns each result over a valid/ready stream. It sits between the tile's operand routing and the ALU instance.

## Interface
- `DATA_WIDTH`, 32: operand/result width; matches the ALU data ports.
- `FUNC_WIDTH`, 3: opcode width; matches `ALU_func`.
- `DEPTH`, 8: context entries; power of two, 2..16.
- `ALU_LATENCY`, 1: cycles from ALU input change to valid `alu_result`; legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `cfg_we`  in  1  context write strobe.
- `cfg_addr`  in  $clog2(DEPTH)  context write address.
- `cfg_wdata`  in  FUNC_WIDTH+1  entry: bit FUNC_WIDTH is `last`; the low bits are the opcode.
- `cfg_err`  out  1  one-cycle pulse when a write is dropped.
- `start`  in  1  begins a program run from entry 0.
- `abort`  in  1  synchronous cancel of a run.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse when the program completes.
- `in_valid` / `in_ready`  in / out  1 / 1  operand handshake.
- `in_data1..3`  in  DATA_WIDTH each  operand triple.
- `alu_func`  out  FUNC_WIDTH  registered opcode to the ALU.
- `alu_in1..3`  out  DATA_WIDTH each  registered operands to the ALU.
- `alu_result`  in  DATA_WIDTH  ALU output.
- `out_valid` / `out_ready`  out / in  1 / 1  result handshake.
- `out_data`  out  DATA_WIDTH  captured result.
- `out_pc`  out  $clog2(DEPTH)  index of the entry that produced `out_data`.

## Operation
- Reset: state is IDLE, and the PC, all outputs and all context entries are 0.
- The FSM has four states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - `busy`=0.
  - `cfg_we` writes the context memory.
  - `start`=1 clears the PC and moves the FSM to ISSUE.
- ISSUE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_data1..3` into `alu_in1..3` and latch the entry's opcode into `alu_func`.
  - Load the latency counter with ALU_LATENCY and move to WAIT.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `alu_result` into `out_data`, set `out_pc` to the PC, set `out_valid`, and move to HOLD.
- HOLD:
  - `out_valid` holds, with `out_data` stable, until `out_ready`.
  - On the handshake, if the entry's `last` bit is set or PC = DEPTH-1, pulse `done` and go to IDLE.
  - Otherwise increment the PC and go to ISSUE.
- `alu_func` and `alu_in*` hold their last values in every state, including after `done`. The ALU inputs never glitch.
- `abort` in any non-IDLE state:
  - Go to IDLE next cycle and drop `out_valid`.
  - Do not pulse `done`, and accept no operand on that cycle: `in_ready` is forced to 0.
- `start` while busy is ignored.
- `cfg_we` while busy is dropped and pulses `cfg_err` the next cycle.
- Simultaneous `start` and `cfg_we` in IDLE: the write completes and the run reads the new value. The context write has priority and the first fetch happens one cycle later.
- The PC wraps only by termination; an entry with `last`=0 at DEPTH-1 still terminates.

## Timing
- `start` sampled at edge 0 gives `busy`=1 and `in_ready`=1 in cycle 1.
- Operand handshake at edge t:
  - `alu_in*` and `alu_func` are valid from cycle t+1.
  - The FSM stays in WAIT for ALU_LATENCY+1 cycles.
  - `out_valid`=1 from cycle t+2+ALU_LATENCY.
- With `out_ready` held high, the minimum step period is ALU_LATENCY+3 cycles. Steps do not overlap.
- `done` is asserted in the cycle after the final output handshake, together with `busy`=0.
- `resetn` assertion mid-run clears state and outputs immediately, with no `done` and no `cfg_err`. The context memory is also cleared.

## Structure
- Shared package `pe_ctrl_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, HOLD);
  - the context entry struct (`last`, `func`);
  - the FUNC_WIDTH and default DATA_WIDTH constants.
- One sub-module, `pe_ctx_mem`: a DEPTH×(FUNC_WIDTH+1) register file with one synchronous write port and one asynchronous read port, reset to 0.

## Test plan
- Program [func 2, func 5 + last], operands (7,3,0) then (9,4,0), `out_ready` tied high, ALU_LATENCY=1:
  - outputs arrive with `out_pc` 0 then 1;
  - `alu_func` reads 2 then 5;
  - `done` pulses once, 4 cycles after the second handshake.
- `out_ready` held low for 5 cycles in HOLD: `out_valid` and `out_data` stay stable, and `in_ready`=0 throughout.
- All 8 entries with `last`=0: exactly 8 results are returned, then `done`, and the PC does not wrap.
- `cfg_we` during a run: the entry is unchanged, `cfg_err` pulses once, and a later read of that entry returns the old opcode.
- `abort` asserted in WAIT, then `start`: the first result is never emitted, `done` does not pulse, and the next run begins at PC 0.
- `resetn` dropped in HOLD with `out_valid`=1: `out_valid`, `busy`, `alu_func` and `alu_in*` read 0 immediately, and `done` does not pulse.
